// File: rtl/vector_pkg.sv
// ----------------------------------------------------------------------------
// vector_pkg : shared types for the vector beam path (sequencer, stepper, DACs)
// Revision   : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package vector_pkg;

  localparam int COORD_W             = 12;
  localparam int JUMP_SETTLE_DEFAULT = 16;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAW   = 2'd1,
    SETTLE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/line_stepper.sv
// ----------------------------------------------------------------------------
// line_stepper : turns absolute draw/jump commands into a Bresenham DAC walk
// Revision     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module line_stepper
  import vector_pkg::*;
#(
  parameter int WIDTH       = COORD_W,
  parameter int JUMP_SETTLE = JUMP_SETTLE_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             draw,
  input  logic             jump,
  output logic             ready,
  output logic [WIDTH-1:0] dac_x,
  output logic [WIDTH-1:0] dac_y,
  output logic             beam_on
);

  localparam int CNT_W = (JUMP_SETTLE > 1) ? $clog2(JUMP_SETTLE) : 1;
  localparam int ERR_W = WIDTH + 2;

  localparam logic [CNT_W-1:0]        C_SETTLE_LOAD = CNT_W'(JUMP_SETTLE - 1);
  localparam logic [CNT_W-1:0]        C_CNT_ONE     = CNT_W'(1);
  localparam logic [WIDTH-1:0]        C_COORD_ONE   = WIDTH'(1);
  localparam logic signed [ERR_W-1:0] C_ERR_ZERO    = '0;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [WIDTH-1:0]        r_x;
  logic [WIDTH-1:0]        r_y;
  logic [WIDTH-1:0]        r_tx;
  logic [WIDTH-1:0]        r_ty;
  logic signed [ERR_W-1:0] r_dx;
  logic signed [ERR_W-1:0] r_dy;
  logic signed [ERR_W-1:0] r_err;
  logic                    r_sx;
  logic                    r_sy;
  logic                    r_beam;
  logic [CNT_W-1:0]        r_cnt;

  logic [WIDTH-1:0]        w_adx;
  logic [WIDTH-1:0]        w_ady;
  logic signed [ERR_W-1:0] w_dx_init;
  logic signed [ERR_W-1:0] w_dy_init;
  logic signed [ERR_W-1:0] w_e2;
  logic                    w_step_x;
  logic                    w_step_y;
  logic signed [ERR_W-1:0] w_err_next;
  logic                    w_at_target;

  // Setup terms for a new line, measured from the current DAC position.
  always_comb begin
    w_adx     = (x > r_x) ? (x - r_x) : (r_x - x);
    w_ady     = (y > r_y) ? (y - r_y) : (r_y - y);
    w_dx_init = $signed({2'b00, w_adx});
    w_dy_init = -$signed({2'b00, w_ady});
  end

  always_comb begin
    w_e2        = r_err <<< 1;
    w_step_x    = (w_e2 >= r_dy);
    w_step_y    = (w_e2 <= r_dx);
    w_err_next  = r_err + (w_step_x ? r_dy : C_ERR_ZERO)
                        + (w_step_y ? r_dx : C_ERR_ZERO);
    w_at_target = (r_x == r_tx) && (r_y == r_ty);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    ready        = 1'b0;
    case (r_state)
      IDLE: begin
        ready = !draw && !jump;
        if (jump) begin
          w_next_state = SETTLE;
        end else if (draw) begin
          w_next_state = DRAW;
        end
      end
      DRAW: begin
        if (w_at_target) begin
          w_next_state = IDLE;
        end
      end
      SETTLE: begin
        if (r_cnt == '0) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x    <= '0;
      r_y    <= '0;
      r_tx   <= '0;
      r_ty   <= '0;
      r_dx   <= '0;
      r_dy   <= '0;
      r_err  <= '0;
      r_sx   <= 1'b0;
      r_sy   <= 1'b0;
      r_beam <= 1'b0;
      r_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (jump) begin
            r_x    <= x;
            r_y    <= y;
            r_beam <= 1'b0;
            r_cnt  <= C_SETTLE_LOAD;
          end else if (draw) begin
            r_tx   <= x;
            r_ty   <= y;
            r_dx   <= w_dx_init;
            r_dy   <= w_dy_init;
            r_err  <= w_dx_init + w_dy_init;
            r_sx   <= (x > r_x);
            r_sy   <= (y > r_y);
            r_beam <= 1'b1;
          end
        end
        DRAW: begin
          if (w_at_target) begin
            r_beam <= 1'b0;
          end else begin
            r_err <= w_err_next;
            if (w_step_x) begin
              r_x <= r_sx ? (r_x + C_COORD_ONE) : (r_x - C_COORD_ONE);
            end
            if (w_step_y) begin
              r_y <= r_sy ? (r_y + C_COORD_ONE) : (r_y - C_COORD_ONE);
            end
          end
        end
        SETTLE: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - C_CNT_ONE;
          end
        end
        default: r_beam <= 1'b0;
      endcase
    end
  end

  assign dac_x   = r_x;
  assign dac_y   = r_y;
  assign beam_on = r_beam;

endmodule

`default_nettype wire

// File: tb/tb_line_stepper.sv
// ----------------------------------------------------------------------------
// tb_line_stepper : line_stepper against a per-cycle beam-path model
// Revision        : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_line_stepper;

  localparam int W  = 12;
  localparam int JS = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         draw;
  logic         jump;
  logic         ready;
  logic [W-1:0] dac_x;
  logic [W-1:0] dac_y;
  logic         beam_on;

  always #5 clk = ~clk;

  line_stepper #(.WIDTH(W), .JUMP_SETTLE(JS)) dut (
    .clk     (clk),
    .reset   (reset),
    .x       (x),
    .y       (y),
    .draw    (draw),
    .jump    (jump),
    .ready   (ready),
    .dac_x   (dac_x),
    .dac_y   (dac_y),
    .beam_on (beam_on)
  );

  typedef struct {
    int fx;
    int fy;
    bit fb;
  } frame_t;

  // Expected outputs for every busy cycle still to come; empty means idle.
  frame_t q[$];
  int     pos_x = 0;
  int     pos_y = 0;
  int     checks = 0;
  int     errors = 0;
  bit     chk_en = 1'b0;
  int     lit_total = 0;
  bit     prev_lit = 1'b0;
  int     prev_x = 0;
  int     prev_y = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference line: the lit points from (x0,y0) to (x1,y1), both endpoints.
  task automatic model_line(input int x0, input int y0, input int x1, input int y1);
    int dx, dy, sx, sy, err, e2, cx, cy;
    frame_t f;
    dx = iabs(x1 - x0);
    dy = -iabs(y1 - y0);
    sx = (x1 > x0) ? 1 : -1;
    sy = (y1 > y0) ? 1 : -1;
    err = dx + dy;
    cx = x0;
    cy = y0;
    forever begin
      f.fx = cx; f.fy = cy; f.fb = 1'b1;
      q.push_back(f);
      if (cx == x1 && cy == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; cx += sx; end
      if (e2 <= dx) begin err += dx; cy += sy; end
    end
  endtask

  always @(negedge clk) begin : p_cmp
    frame_t f;
    frame_t s;
    int     ex_ready;
    if (!reset) begin
      q.delete();
      pos_x    = 0;
      pos_y    = 0;
      prev_lit = 1'b0;
    end else if (chk_en) begin
      if (q.size() > 0) begin
        f = q.pop_front();
        ex_ready = 0;
      end else begin
        f.fx = pos_x; f.fy = pos_y; f.fb = 1'b0;
        ex_ready = (draw || jump) ? 0 : 1;
        if (jump) begin
          s.fx = int'(x); s.fy = int'(y); s.fb = 1'b0;
          repeat (JS) q.push_back(s);
          pos_x = int'(x);
          pos_y = int'(y);
        end else if (draw) begin
          model_line(pos_x, pos_y, int'(x), int'(y));
          pos_x = int'(x);
          pos_y = int'(y);
        end
      end
      check("dac_x", int'(dac_x), f.fx);
      check("dac_y", int'(dac_y), f.fy);
      check("beam_on", int'(beam_on), int'(f.fb));
      check("ready", int'(ready), ex_ready);
      if (beam_on && prev_lit) begin
        check("step_x_le1", int'(iabs(int'(dac_x) - prev_x) <= 1), 1);
        check("step_y_le1", int'(iabs(int'(dac_y) - prev_y) <= 1), 1);
      end
      if (beam_on) lit_total++;
      prev_lit = beam_on;
      prev_x   = int'(dac_x);
      prev_y   = int'(dac_y);
    end
  end

  task automatic cmd(input bit d, input bit j, input int tx, input int ty);
    @(posedge clk); #1;
    draw = d; jump = j; x = W'(tx); y = W'(ty);
    @(posedge clk); #1;
    draw = 1'b0; jump = 1'b0; x = W'($urandom); y = W'($urandom);
  endtask

  task automatic wait_idle(output int busy);
    bit done;
    busy = 0;
    done = 1'b0;
    for (int i = 0; i < 10000 && !done; i++) begin
      @(negedge clk);
      if (ready) done = 1'b1;
      else busy++;
    end
    if (!done) check("idle_timeout", busy, -1);
  endtask

  initial begin : p_main
    int b;
    int l0;
    int tx, ty;
    reset = 1'b0; draw = 1'b1; jump = 1'b0; x = W'(7); y = W'(9);

    // Reset with a draw pulse held across release.
    repeat (3) @(posedge clk);
    #1;
    check("rst_dac_x", int'(dac_x), 0);
    check("rst_dac_y", int'(dac_y), 0);
    check("rst_beam", int'(beam_on), 0);
    check("rst_ready_cmd", int'(ready), 0);
    reset = 1'b1;
    #2 draw = 1'b0;
    @(negedge clk);
    check("rst_ready", int'(ready), 1);
    check("rst_beam2", int'(beam_on), 0);
    chk_en = 1'b1;

    // Jump to (50,10).
    l0 = lit_total;
    cmd(0, 1, 50, 10);
    wait_idle(b);
    check("jump_busy", b, 16);
    check("jump_lit", lit_total - l0, 0);
    check("jump_x", int'(dac_x), 50);
    check("jump_y", int'(dac_y), 10);

    // Draw (50,10) -> (0,40).
    l0 = lit_total;
    cmd(1, 0, 0, 40);
    wait_idle(b);
    check("draw_busy", b, 51);
    check("draw_lit", lit_total - l0, 51);
    check("draw_end_x", int'(dac_x), 0);
    check("draw_end_y", int'(dac_y), 40);

    // Zero-length draw: one dot.
    l0 = lit_total;
    cmd(1, 0, 0, 40);
    wait_idle(b);
    check("dot_busy", b, 1);
    check("dot_lit", lit_total - l0, 1);

    // draw+jump together behaves as jump.
    l0 = lit_total;
    cmd(1, 1, 200, 300);
    wait_idle(b);
    check("both_busy", b, 16);
    check("both_lit", lit_total - l0, 0);
    check("both_x", int'(dac_x), 200);
    check("both_y", int'(dac_y), 300);

    // A draw pulse during DRAW is ignored.
    cmd(1, 0, 100, 100);
    repeat (3) @(posedge clk);
    cmd(1, 0, 5, 5);
    wait_idle(b);
    check("ign_x", int'(dac_x), 100);
    check("ign_y", int'(dac_y), 100);

    // Full-scale diagonal.
    cmd(0, 1, 0, 0);
    wait_idle(b);
    l0 = lit_total;
    cmd(1, 0, 4095, 4095);
    wait_idle(b);
    check("full_busy", b, 4096);
    check("full_lit", lit_total - l0, 4096);
    check("full_x", int'(dac_x), 4095);
    check("full_y", int'(dac_y), 4095);

    // Randomised commands, with stray pulses while busy.
    for (int n = 0; n < 80; n++) begin
      tx = $urandom_range(0, 400);
      ty = $urandom_range(0, 400);
      if ($urandom_range(0, 9) < 3) cmd(0, 1, tx, ty);
      else cmd($urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0, tx, ty);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 5)) @(posedge clk);
        cmd($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 400), $urandom_range(0, 400));
      end
      wait_idle(b);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    // Reset in the middle of a long draw.
    cmd(1, 0, 4000, 10);
    repeat (10) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("abort_beam", int'(beam_on), 0);
    check("abort_x", int'(dac_x), 0);
    check("abort_y", int'(dac_y), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("abort_ready", int'(ready), 1);
    l0 = lit_total;
    cmd(1, 0, 3, 7);
    wait_idle(b);
    check("post_lit", lit_total - l0, 8);
    check("post_x", int'(dac_x), 3);
    check("post_y", int'(dac_y), 7);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
